// File: rtl/sensor_conditioner_pkg.sv
// Shared types and default timing constants for the speed-alert sign front end.
package sensor_conditioner_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } cond_state_e;

    // Defaults shared with the downstream speed-threshold logic.
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000;
    localparam int unsigned DEFAULT_ARM_TIMEOUT     = 50_000_000;
    localparam int unsigned DEFAULT_CNT_W           = 32;

endpackage

// File: rtl/sensor_conditioner_if.sv
// Sensor bus between the raw loop/beam lines and the conditioned pass events.
// SENSOR_BIDIR_EN adds the dir signal (0 = 1->2, 1 = 2->1).
interface sensor_conditioner_if;
    logic sensor1_raw;
    logic sensor2_raw;
    logic sensor1_clean;
    logic sensor2_clean;
    logic start;
    logic stop;
    logic abort;
    logic armed;
`ifdef SENSOR_BIDIR_EN
    logic dir;

    modport master (
        output sensor1_raw, sensor2_raw,
        input  sensor1_clean, sensor2_clean, start, stop, abort, armed, dir
    );
    modport slave (
        input  sensor1_raw, sensor2_raw,
        output sensor1_clean, sensor2_clean, start, stop, abort, armed, dir
    );
`else
    modport master (
        output sensor1_raw, sensor2_raw,
        input  sensor1_clean, sensor2_clean, start, stop, abort, armed
    );
    modport slave (
        input  sensor1_raw, sensor2_raw,
        output sensor1_clean, sensor2_clean, start, stop, abort, armed
    );
`endif
endinterface

// File: rtl/sensor_debounce.sv
// One sensor channel: 2-FF synchroniser, debounce counter and rising-edge pulse of the clean level.
module sensor_debounce
    import sensor_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean,
    output logic rise_c
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             synced;
    logic             clean_prev;
    logic [CNT_W-1:0] cnt;

    // Clean level only follows synced after DEBOUNCE_CYCLES consecutive differing cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 1'b0;
            synced     <= 1'b0;
            clean      <= 1'b0;
            clean_prev <= 1'b0;
            cnt        <= '0;
        end else begin
            sync1      <= raw;
            synced     <= sync1;
            clean_prev <= clean;
            if (synced == clean) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                clean <= ~clean;
                cnt   <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign rise_c = clean & ~clean_prev;

endmodule

// File: rtl/sensor_conditioner.sv
// Conditions the two vehicle sensors and pairs entry/exit edges into start/stop/abort pulses.
// SENSOR_BIDIR_EN also recognises 2->1 passes and exposes the latched direction on dir.
module sensor_conditioner
    import sensor_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned ARM_TIMEOUT     = DEFAULT_ARM_TIMEOUT,
    parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sensor_conditioner_if.slave   bus
);

    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(ARM_TIMEOUT - 1);

    logic             rise1_c;
    logic             rise2_c;
    logic             done_c;
    logic             again_c;
    cond_state_e      state;
    logic [CNT_W-1:0] timer;
    logic             start;
    logic             stop;
    logic             abort;

    sensor_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (bus.sensor1_raw),
        .clean  (bus.sensor1_clean),
        .rise_c (rise1_c)
    );

    sensor_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (bus.sensor2_raw),
        .clean  (bus.sensor2_clean),
        .rise_c (rise2_c)
    );

`ifdef SENSOR_BIDIR_EN
    logic dir;

    // The sensor that armed the pass re-triggers it; the other one completes it.
    assign done_c  = dir ? rise1_c : rise2_c;
    assign again_c = dir ? rise2_c : rise1_c;
    assign bus.dir = dir;
`else
    assign done_c  = rise2_c;
    assign again_c = rise1_c;
`endif

    // Pass tracker: completion beats re-trigger, re-trigger beats timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            timer <= '0;
            start <= 1'b0;
            stop  <= 1'b0;
            abort <= 1'b0;
`ifdef SENSOR_BIDIR_EN
            dir   <= 1'b0;
`endif
        end else begin
            start <= 1'b0;
            stop  <= 1'b0;
            abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise1_c) begin
                        start <= 1'b1;
                        timer <= '0;
                        state <= ARMED;
`ifdef SENSOR_BIDIR_EN
                        dir   <= 1'b0;
                    end else if (rise2_c) begin
                        start <= 1'b1;
                        timer <= '0;
                        state <= ARMED;
                        dir   <= 1'b1;
`endif
                    end
                end
                ARMED: begin
                    if (done_c) begin
                        stop  <= 1'b1;
                        state <= IDLE;
                    end else if (again_c) begin
                        start <= 1'b1;
                        timer <= '0;
                    end else if (timer == TIMER_LAST) begin
                        abort <= 1'b1;
                        state <= IDLE;
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.start = start;
    assign bus.stop  = stop;
    assign bus.abort = abort;
    assign bus.armed = (state == ARMED);

endmodule
